// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-back port arbiter.
package wb_arb_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    // One queued MDU result; live drops when a newer pipe write to the same rd wins.
    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // Source that owns the write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_HEAD   = 2'd1,
        GNT_PIPE   = 2'd2,
        GNT_BYPASS = 2'd3
    } wb_grant_e;

    function automatic logic [NREG-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        logic [NREG-1:0] oh;
        oh     = '0;
        oh[rd] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular FIFO of MDU results with per-entry live bits. Entries overtaken by a
// pipe write to the same register are squashed in place and auto-popped once
// they reach the head, so they never consume a write-port cycle.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic [XLEN-1:0]   push_data,
    input  logic              pop,
    input  logic              squash,
    input  logic [REG_AW-1:0] squash_rd,
    output logic              head_live,
    output logic [REG_AW-1:0] head_rd,
    output logic [XLEN-1:0]   head_data,
    output logic              empty,
    output logic              full,
    output logic [NREG-1:0]   pend_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  live;
    logic [DEPTH-1:0]  live_nxt;
    logic [REG_AW-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Slots outside the occupied range always hold live=0, so live[rd_ptr] alone
    // tells whether a writable head exists.
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head_live = live[rd_ptr];
    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign do_push   = push & ~full;
    assign do_pop    = (~empty & ~live[rd_ptr]) | (pop & live[rd_ptr]);

    // Next live bits: squash before enqueue so a same-cycle arrival survives.
    always_comb begin
        live_nxt = live;
        for (int i = 0; i < DEPTH; i++) begin
            if (squash && live[i] && (rd_mem[i] == squash_rd)) begin
                live_nxt[i] = 1'b0;
            end
        end
        if (do_pop) begin
            live_nxt[rd_ptr] = 1'b0;
        end
        if (do_push) begin
            live_nxt[wr_ptr] = 1'b1;
        end
    end

    // Pointer, occupancy and live-bit state; cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            live   <= '0;
        end else begin
            live <= live_nxt;
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage; only meaningful where the matching live bit is set.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Registers still owed a write by a queued result.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
                pend_mask = pend_mask | rd_onehot(rd_mem[i]);
            end
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single integer register-file write port between the in-order W
// stage and the MDU. The pipe normally wins; MDU results wait in a small FIFO
// and a head denied MAX_WAIT cycles steals the port for one cycle via stall.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_i_valid,
    input  logic              pipe_i_reg_wen,
    input  logic [REG_AW-1:0] pipe_i_rd,
    input  logic [XLEN-1:0]   pipe_i_data,
    output logic              arb_o_pipe_stall,
    input  logic              mdu_i_valid,
    input  logic [REG_AW-1:0] mdu_i_rd,
    input  logic [XLEN-1:0]   mdu_i_data,
    output logic              mdu_o_ready,
    output logic              arb_o_reg_wen,
    output logic [REG_AW-1:0] arb_o_rd,
    output logic [XLEN-1:0]   arb_o_data,
    output logic [NREG-1:0]   arb_o_pend_mask
);

    localparam int             WC_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);

    logic              pipe_req;
    logic              mdu_live;
    logic              wait_hit;
    logic [WC_W-1:0]   wait_cnt;
    wb_grant_e         grant;
    logic              fifo_head_live;
    logic [REG_AW-1:0] fifo_head_rd;
    logic [XLEN-1:0]   fifo_head_data;
    logic              fifo_empty;
    logic              fifo_full;

    // rst_n gating keeps the port quiet while reset is held, before any edge.
    assign pipe_req    = rst_n & pipe_i_valid & pipe_i_reg_wen & (pipe_i_rd != '0);
    assign mdu_o_ready = rst_n & ~fifo_full;
    assign mdu_live    = mdu_i_valid & mdu_o_ready & (mdu_i_rd != '0);
    assign wait_hit    = (wait_cnt == WAIT_MAX);

    wb_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mdu_live & (grant != GNT_BYPASS)),
        .push_rd   (mdu_i_rd),
        .push_data (mdu_i_data),
        .pop       (grant == GNT_HEAD),
        .squash    (grant == GNT_PIPE),
        .squash_rd (pipe_i_rd),
        .head_live (fifo_head_live),
        .head_rd   (fifo_head_rd),
        .head_data (fifo_head_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .pend_mask (arb_o_pend_mask)
    );

    // Port owner: starved or uncontested head, then pipe, then empty-FIFO bypass.
    always_comb begin
        grant = GNT_NONE;
        if (fifo_head_live && (!pipe_req || wait_hit)) begin
            grant = GNT_HEAD;
        end else if (pipe_req) begin
            grant = GNT_PIPE;
        end else if (fifo_empty && mdu_live) begin
            grant = GNT_BYPASS;
        end
    end

    // Write-port mux; address and data read zero when nobody writes.
    always_comb begin
        arb_o_reg_wen = 1'b0;
        arb_o_rd      = '0;
        arb_o_data    = '0;
        case (grant)
            GNT_HEAD: begin
                arb_o_reg_wen = 1'b1;
                arb_o_rd      = fifo_head_rd;
                arb_o_data    = fifo_head_data;
            end
            GNT_PIPE: begin
                arb_o_reg_wen = 1'b1;
                arb_o_rd      = pipe_i_rd;
                arb_o_data    = pipe_i_data;
            end
            GNT_BYPASS: begin
                arb_o_reg_wen = 1'b1;
                arb_o_rd      = mdu_i_rd;
                arb_o_data    = mdu_i_data;
            end
            default: ;
        endcase
    end

    assign arb_o_pipe_stall = (grant == GNT_HEAD) & pipe_req;

    // Starvation counter for the live head; saturates so the stall lasts one grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!fifo_head_live || (grant == GNT_HEAD)) begin
            wait_cnt <= '0;
        end else if (!wait_hit) begin
            wait_cnt <= wait_cnt + WC_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a random run,
// all compared cycle by cycle against a queue-based model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_i_valid;
    logic        pipe_i_reg_wen;
    logic [4:0]  pipe_i_rd;
    logic [63:0] pipe_i_data;
    logic        arb_o_pipe_stall;
    logic        mdu_i_valid;
    logic [4:0]  mdu_i_rd;
    logic [63:0] mdu_i_data;
    logic        mdu_o_ready;
    logic        arb_o_reg_wen;
    logic [4:0]  arb_o_rd;
    logic [63:0] arb_o_data;
    logic [31:0] arb_o_pend_mask;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pipe_i_valid     (pipe_i_valid),
        .pipe_i_reg_wen   (pipe_i_reg_wen),
        .pipe_i_rd        (pipe_i_rd),
        .pipe_i_data      (pipe_i_data),
        .arb_o_pipe_stall (arb_o_pipe_stall),
        .mdu_i_valid      (mdu_i_valid),
        .mdu_i_rd         (mdu_i_rd),
        .mdu_i_data       (mdu_i_data),
        .mdu_o_ready      (mdu_o_ready),
        .arb_o_reg_wen    (arb_o_reg_wen),
        .arb_o_rd         (arb_o_rd),
        .arb_o_data       (arb_o_data),
        .arb_o_pend_mask  (arb_o_pend_mask)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of {live, rd, data} plus a denied-cycle counter.
    typedef struct {
        bit        live;
        bit [4:0]  rd;
        bit [63:0] data;
    } ment_t;

    typedef struct {
        bit        wen;
        bit [4:0]  rd;
        bit [63:0] data;
        bit        stall;
        bit        ready;
        bit [31:0] mask;
        int        kind;   // 0 none, 1 fifo head, 2 pipe, 3 bypass
    } exp_t;

    ment_t mq[$];
    int    mwait = 0;

    bit [63:0] xdut [32];
    bit        x9_got_one = 1'b0;

    // Register file as actually written by the DUT.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && arb_o_reg_wen === 1'b1) begin
            xdut[arb_o_rd] <= arb_o_data;
            if (arb_o_rd == 5'd9 && arb_o_data == 64'd1) x9_got_one <= 1'b1;
        end
    end

    function automatic exp_t model_eval();
        exp_t e;
        bit   preq;
        bit   hlive;
        e     = '{default: 0};
        preq  = pipe_i_valid && pipe_i_reg_wen && (pipe_i_rd != 0);
        e.ready = (mq.size() < DEPTH);
        hlive = (mq.size() > 0) && mq[0].live;
        foreach (mq[i]) if (mq[i].live) e.mask[mq[i].rd] = 1'b1;
        if (hlive && (!preq || mwait >= MAX_WAIT)) begin
            e.kind = 1; e.wen = 1; e.rd = mq[0].rd; e.data = mq[0].data; e.stall = preq;
        end else if (preq) begin
            e.kind = 2; e.wen = 1; e.rd = pipe_i_rd; e.data = pipe_i_data;
        end else if (mq.size() == 0 && mdu_i_valid && e.ready && mdu_i_rd != 0) begin
            e.kind = 3; e.wen = 1; e.rd = mdu_i_rd; e.data = mdu_i_data;
        end
        return e;
    endfunction

    task automatic model_commit();
        exp_t  e;
        bit    hlive;
        bit    do_pop;
        ment_t t;
        e      = model_eval();
        hlive  = (mq.size() > 0) && mq[0].live;
        do_pop = (mq.size() > 0) && (e.kind == 1 || !mq[0].live);
        if (e.kind == 2) begin
            foreach (mq[i]) begin
                if (mq[i].rd == pipe_i_rd) begin
                    t = mq[i]; t.live = 1'b0; mq[i] = t;
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (!hlive || e.kind == 1) mwait = 0;
        else if (mwait < MAX_WAIT) mwait++;
        if (mdu_i_valid && e.ready && mdu_i_rd != 0 && e.kind != 3) begin
            t.live = 1'b1; t.rd = mdu_i_rd; t.data = mdu_i_data;
            mq.push_back(t);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mwait = 0;
    endtask

    function automatic logic [103:0] dut_vec();
        return {arb_o_reg_wen, arb_o_rd, arb_o_data, arb_o_pipe_stall, mdu_o_ready, arb_o_pend_mask};
    endfunction

    function automatic logic [103:0] exp_vec(exp_t e);
        return {e.wen, e.rd, e.data, e.stall, e.ready, e.mask};
    endfunction

    task automatic drive_pipe(input bit v, input bit w, input logic [4:0] rd, input logic [63:0] d);
        pipe_i_valid = v; pipe_i_reg_wen = w; pipe_i_rd = rd; pipe_i_data = d;
    endtask

    task automatic drive_mdu(input bit v, input logic [4:0] rd, input logic [63:0] d);
        mdu_i_valid = v; mdu_i_rd = rd; mdu_i_data = d;
    endtask

    task automatic idle();
        drive_pipe(0, 0, 5'd0, 64'd0);
        drive_mdu(0, 5'd0, 64'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_commit();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_pipe(1, 1, 5'd3, 64'h33);
        drive_mdu(1, 5'd5, 64'h55);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({arb_o_reg_wen, mdu_o_ready, arb_o_pipe_stall} !== 3'b000)
            begin errors++; $display("FAIL rst_ctrl wen/ready/stall=%b required 000", {arb_o_reg_wen, mdu_o_ready, arb_o_pipe_stall}); end
        checks++;
        if ({arb_o_pend_mask, arb_o_rd, arb_o_data} !== 101'd0)
            begin errors++; $display("FAIL rst_outputs mask=%h rd=%0d data=%h required all zero", arb_o_pend_mask, arb_o_rd, arb_o_data); end
        rst_n = 1'b1;
        model_reset();
        idle();
        #1;
        checks++;
        if (mdu_o_ready !== 1'b1)
            begin errors++; $display("FAIL rst_release_ready got=%b required 1", mdu_o_ready); end
        advance();
    endtask

    task automatic test_bypass();
        exp_t e;
        drive_mdu(1, 5'd5, 64'hAB);
        @(negedge clk);
        e = model_eval();
        checks++;
        if ({arb_o_reg_wen, arb_o_rd, arb_o_data, arb_o_pend_mask} !== {1'b1, 5'd5, 64'hAB, 32'd0})
            begin errors++; $display("FAIL bypass_write wen=%b rd=%0d data=%h mask=%h required 1/5/ab/0", arb_o_reg_wen, arb_o_rd, arb_o_data, arb_o_pend_mask); end
        checks++;
        if (dut_vec() !== exp_vec(e)) begin errors++; $display("FAIL bypass_model got=%h required %h", dut_vec(), exp_vec(e)); end
        advance();
        idle();
        @(negedge clk);
        checks++;
        if ({arb_o_reg_wen, arb_o_pend_mask} !== 33'd0)
            begin errors++; $display("FAIL bypass_after wen=%b mask=%h required 0/0", arb_o_reg_wen, arb_o_pend_mask); end
        advance();
    endtask

    task automatic test_priority();
        exp_t e;
        for (int c = 0; c < 7; c++) begin
            drive_pipe(1, 1, 5'd3, 64'h300 + 64'(c));
            if (c == 0) drive_mdu(1, 5'd7, 64'h77);
            else        drive_mdu(0, 5'd0, 64'd0);
            @(negedge clk);
            e = model_eval();
            checks++;
            if (dut_vec() !== exp_vec(e)) begin errors++; $display("FAIL prio_model c=%0d got=%h required %h", c, dut_vec(), exp_vec(e)); end
            if (c >= 1 && c <= 4) begin
                checks++;
                if ({arb_o_pipe_stall, arb_o_rd, arb_o_pend_mask[7]} !== {1'b0, 5'd3, 1'b1})
                    begin errors++; $display("FAIL prio_pipe c=%0d stall=%b rd=%0d mask7=%b required 0/3/1", c, arb_o_pipe_stall, arb_o_rd, arb_o_pend_mask[7]); end
            end
            if (c == 5) begin
                checks++;
                if ({arb_o_pipe_stall, arb_o_reg_wen, arb_o_rd, arb_o_data} !== {1'b1, 1'b1, 5'd7, 64'h77})
                    begin errors++; $display("FAIL prio_forced stall=%b wen=%b rd=%0d data=%h required 1/1/7/77", arb_o_pipe_stall, arb_o_reg_wen, arb_o_rd, arb_o_data); end
            end
            if (c == 6) begin
                checks++;
                if ({arb_o_pipe_stall, arb_o_rd, arb_o_pend_mask[7]} !== {1'b0, 5'd3, 1'b0})
                    begin errors++; $display("FAIL prio_after stall=%b rd=%0d mask7=%b required 0/3/0", arb_o_pipe_stall, arb_o_rd, arb_o_pend_mask[7]); end
            end
            advance();
        end
        idle();
        advance();
    endtask

    task automatic test_full();
        exp_t e;
        int   accepted  = 0;
        int   stall_cyc = -1;
        int   acc3_cyc  = -1;
        bit   saw_low   = 1'b0;
        for (int c = 0; c < 30 && accepted < 3; c++) begin
            drive_pipe(1, 1, 5'd3, 64'(c));
            drive_mdu(1, 5'(10 + accepted), 64'hA0 + 64'(accepted));
            @(negedge clk);
            e = model_eval();
            checks++;
            if (dut_vec() !== exp_vec(e)) begin errors++; $display("FAIL full_model c=%0d got=%h required %h", c, dut_vec(), exp_vec(e)); end
            if (accepted == 2 && !saw_low) begin
                saw_low = 1'b1;
                checks++;
                if (mdu_o_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low c=%0d ready=%b required 0", c, mdu_o_ready); end
            end
            if (arb_o_pipe_stall === 1'b1 && stall_cyc < 0) stall_cyc = c;
            if (mdu_o_ready === 1'b1) begin
                accepted++;
                if (accepted == 3) acc3_cyc = c;
            end
            advance();
        end
        checks++;
        if (stall_cyc != 5 || acc3_cyc != 6)
            begin errors++; $display("FAIL full_timing stall_cycle=%0d third_accept=%0d required 5/6", stall_cyc, acc3_cyc); end
        idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            e = model_eval();
            checks++;
            if (dut_vec() !== exp_vec(e)) begin errors++; $display("FAIL full_drain c=%0d got=%h required %h", c, dut_vec(), exp_vec(e)); end
            advance();
        end
        checks++;
        if (arb_o_pend_mask !== 32'd0 || xdut[11] !== 64'hA1 || xdut[12] !== 64'hA2)
            begin errors++; $display("FAIL full_drained mask=%h x11=%h x12=%h required 0/a1/a2", arb_o_pend_mask, xdut[11], xdut[12]); end
    endtask

    task automatic test_squash();
        exp_t e;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: begin drive_pipe(1, 1, 5'd3, 64'h30); drive_mdu(1, 5'd9, 64'd1); end
                1: begin drive_pipe(1, 1, 5'd9, 64'd2);  drive_mdu(1, 5'd9, 64'd3); end
                4: begin drive_pipe(0, 0, 5'd0, 64'd0);  drive_mdu(1, 5'd4, 64'h44); end
                default: idle();
            endcase
            @(negedge clk);
            e = model_eval();
            checks++;
            if (dut_vec() !== exp_vec(e)) begin errors++; $display("FAIL squash_model c=%0d got=%h required %h", c, dut_vec(), exp_vec(e)); end
            if (c == 1) begin
                checks++;
                if ({arb_o_pend_mask[9], arb_o_reg_wen, arb_o_rd, arb_o_data, arb_o_pipe_stall} !== {1'b1, 1'b1, 5'd9, 64'd2, 1'b0})
                    begin errors++; $display("FAIL squash_pipe mask9=%b wen=%b rd=%0d data=%h stall=%b required 1/1/9/2/0", arb_o_pend_mask[9], arb_o_reg_wen, arb_o_rd, arb_o_data, arb_o_pipe_stall); end
            end
            if (c == 2) begin
                checks++;
                if ({arb_o_reg_wen, arb_o_pend_mask[9]} !== 2'b01)
                    begin errors++; $display("FAIL squash_dead_head wen=%b mask9=%b required 0/1", arb_o_reg_wen, arb_o_pend_mask[9]); end
            end
            if (c == 3) begin
                checks++;
                if ({arb_o_reg_wen, arb_o_rd, arb_o_data} !== {1'b1, 5'd9, 64'd3})
                    begin errors++; $display("FAIL squash_survivor wen=%b rd=%0d data=%h required 1/9/3", arb_o_reg_wen, arb_o_rd, arb_o_data); end
            end
            if (c == 4) begin
                checks++;
                if ({arb_o_reg_wen, arb_o_rd, arb_o_data, arb_o_pend_mask} !== {1'b1, 5'd4, 64'h44, 32'd0})
                    begin errors++; $display("FAIL squash_empty_bypass wen=%b rd=%0d data=%h mask=%h required 1/4/44/0", arb_o_reg_wen, arb_o_rd, arb_o_data, arb_o_pend_mask); end
            end
            advance();
        end
        idle();
        checks++;
        if (x9_got_one !== 1'b0 || xdut[9] !== 64'd3)
            begin errors++; $display("FAIL squash_x9 stale_write=%b x9=%h required 0/3", x9_got_one, xdut[9]); end
    endtask

    task automatic test_rd0_and_reset();
        exp_t e;
        drive_pipe(1, 1, 5'd0, 64'hDEAD);
        drive_mdu(1, 5'd0, 64'hBEEF);
        @(negedge clk);
        checks++;
        if ({arb_o_reg_wen, mdu_o_ready, arb_o_pend_mask} !== {1'b0, 1'b1, 32'd0})
            begin errors++; $display("FAIL rd0_ignored wen=%b ready=%b mask=%h required 0/1/0", arb_o_reg_wen, mdu_o_ready, arb_o_pend_mask); end
        advance();
        idle();
        drive_mdu(1, 5'd6, 64'h66);
        @(negedge clk);
        checks++;
        if ({arb_o_reg_wen, arb_o_rd, arb_o_data} !== {1'b1, 5'd6, 64'h66})
            begin errors++; $display("FAIL rd0_not_queued wen=%b rd=%0d data=%h required 1/6/66", arb_o_reg_wen, arb_o_rd, arb_o_data); end
        advance();
        drive_pipe(1, 1, 5'd3, 64'h31); drive_mdu(1, 5'd12, 64'hC);
        advance();
        drive_mdu(1, 5'd13, 64'hD);
        advance();
        drive_mdu(0, 5'd0, 64'd0);
        @(negedge clk);
        e = model_eval();
        checks++;
        if (dut_vec() !== exp_vec(e) || arb_o_pend_mask !== 32'h0000_3000)
            begin errors++; $display("FAIL midq_before got=%h required %h", dut_vec(), exp_vec(e)); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({arb_o_reg_wen, mdu_o_ready, arb_o_pipe_stall, arb_o_pend_mask} !== 35'd0)
            begin errors++; $display("FAIL midq_reset wen=%b ready=%b stall=%b mask=%h required all 0", arb_o_reg_wen, mdu_o_ready, arb_o_pipe_stall, arb_o_pend_mask); end
        model_reset();
        advance();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        drive_mdu(1, 5'd8, 64'h88);
        #1;
        e = model_eval();
        checks++;
        if (dut_vec() !== exp_vec(e) || {arb_o_reg_wen, arb_o_rd, arb_o_pend_mask} !== {1'b1, 5'd8, 32'd0})
            begin errors++; $display("FAIL midq_after got=%h required %h", dut_vec(), exp_vec(e)); end
        advance();
        idle();
    endtask

    task automatic test_random();
        exp_t e;
        bit   rdy_seen = 1'b1;
        int   bad      = 0;
        for (int c = 0; c < 400; c++) begin
            if (!(mdu_i_valid && !rdy_seen)) begin
                drive_mdu($urandom_range(0, 1), 5'($urandom_range(0, 7)), {$urandom(), $urandom()});
            end
            drive_pipe($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 7)), {$urandom(), $urandom()});
            @(negedge clk);
            rdy_seen = mdu_o_ready;
            e = model_eval();
            checks++;
            if (dut_vec() !== exp_vec(e)) begin
                errors++;
                if (bad < 10) $display("FAIL random c=%0d got=%h required %h", c, dut_vec(), exp_vec(e));
                bad++;
            end
            advance();
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        test_reset();
        test_bypass();
        test_priority();
        test_full();
        test_squash();
        test_rd0_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
